// File: rtl/dualprio_pkg.sv
// Shared types and helpers for the dual-request scheduler and its 12-line
// dual-priority encoder.
package dualprio_pkg;

  localparam int N  = 12;
  localparam int IW = 4;

  typedef logic [N-1:0]  req_vec_t;
  typedef logic [IW-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE1 = 2'd1,
    ISSUE2 = 2'd2
  } sched_state_t;

  function automatic req_vec_t onehot(input idx_t idx);
    onehot = req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/dualpriority_encoder.sv
// Combinational 12-line encoder: highest set index and next-highest set index.
// Indices with nothing set read as 0; any_set tells an empty vector apart.
module dualpriority_encoder
  import dualprio_pkg::*;
(
  input  logic [N-1:0]  req,
  output logic [IW-1:0] first,
  output logic [IW-1:0] second,
  output logic          any_set
);

  logic found_first;
  logic found_second;

  always_comb begin
    first        = '0;
    second       = '0;
    found_first  = 1'b0;
    found_second = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (!found_first) begin
          first       = IW'(i);
          found_first = 1'b1;
        end else if (!found_second) begin
          second       = IW'(i);
          found_second = 1'b1;
        end
      end
    end
  end

  assign any_set = found_first;

endmodule

// File: rtl/dual_request_scheduler.sv
// Sticky request collector that issues batches of up to two highest-priority
// grants over a valid/ready handshake, clearing each served line.
module dual_request_scheduler
  import dualprio_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req_in,
  input  logic          flush,
  output logic          gnt_valid,
  input  logic          gnt_ready,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_last,
  output logic [N-1:0]  pend,
  output logic          busy,
  output logic [CW-1:0] served_cnt
);

  // Handshake: a grant transfers on any cycle where gnt_valid & gnt_ready;
  // once raised, gnt_valid/gnt_id/gnt_last hold until that transfer.
  sched_state_t  state_q, state_d;
  req_vec_t      pend_q, pend_d;
  idx_t          b_first_q, b_first_d;
  idx_t          b_second_q, b_second_d;
  logic          b_two_q, b_two_d;
  logic          gnt_valid_q, gnt_valid_d;
  idx_t          gnt_id_q, gnt_id_d;
  logic          gnt_last_q, gnt_last_d;
  logic [CW-1:0] served_cnt_q, served_cnt_d;

  idx_t     enc_first;
  idx_t     enc_second;
  logic     enc_any;
  logic     hs;
  req_vec_t clr_mask;

  dualpriority_encoder u_enc (
    .req     (pend_q),
    .first   (enc_first),
    .second  (enc_second),
    .any_set (enc_any)
  );

  assign hs       = gnt_valid_q & gnt_ready;
  assign clr_mask = hs ? onehot(gnt_id_q) : '0;

  always_comb begin
    state_d      = state_q;
    b_first_d    = b_first_q;
    b_second_d   = b_second_q;
    b_two_d      = b_two_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_id_d     = gnt_id_q;
    gnt_last_d   = gnt_last_q;
    // A re-request in the handshake cycle survives the clear.
    pend_d       = (pend_q & ~clr_mask) | req_in;
    served_cnt_d = served_cnt_q + {{(CW-1){1'b0}}, hs};

    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          b_first_d   = enc_first;
          b_second_d  = enc_second;
          b_two_d     = |(pend_q & ~onehot(enc_first));
          state_d     = ISSUE1;
          gnt_valid_d = 1'b1;
          gnt_id_d    = enc_first;
          gnt_last_d  = ~(|(pend_q & ~onehot(enc_first)));
        end
      end
      ISSUE1: begin
        if (hs) begin
          if (b_two_q) begin
            state_d     = ISSUE2;
            gnt_valid_d = 1'b1;
            gnt_id_d    = b_second_q;
            gnt_last_d  = 1'b1;
          end else begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
            gnt_last_d  = 1'b0;
          end
        end
      end
      ISSUE2: begin
        if (hs) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          gnt_last_d  = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
        gnt_last_d  = 1'b0;
      end
    endcase

    // Flush drops the batch and pending set; a coincident handshake is void.
    if (flush) begin
      state_d      = IDLE;
      pend_d       = '0;
      gnt_valid_d  = 1'b0;
      gnt_last_d   = 1'b0;
      served_cnt_d = served_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      b_first_q    <= '0;
      b_second_q   <= '0;
      b_two_q      <= 1'b0;
      gnt_valid_q  <= 1'b0;
      gnt_id_q     <= '0;
      gnt_last_q   <= 1'b0;
      served_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      b_first_q    <= b_first_d;
      b_second_q   <= b_second_d;
      b_two_q      <= b_two_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_id_q     <= gnt_id_d;
      gnt_last_q   <= gnt_last_d;
      served_cnt_q <= served_cnt_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_id     = gnt_id_q;
  assign gnt_last   = gnt_last_q;
  assign pend       = pend_q;
  assign busy       = (state_q != IDLE);
  assign served_cnt = served_cnt_q;

endmodule

// File: tb/tb_dual_request_scheduler.sv
// Bench for dual_request_scheduler: directed scenarios plus random traffic,
// checked every cycle against a batch-queue reference model.
module tb_dual_request_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] req_in;
  logic        flush;
  logic        gnt_valid;
  logic        gnt_ready;
  logic [3:0]  gnt_id;
  logic        gnt_last;
  logic [11:0] pend;
  logic        busy;
  logic [15:0] served_cnt;

  always #5 clk = ~clk;

  dual_request_scheduler #(.CW(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_in     (req_in),
    .flush      (flush),
    .gnt_valid  (gnt_valid),
    .gnt_ready  (gnt_ready),
    .gnt_id     (gnt_id),
    .gnt_last   (gnt_last),
    .pend       (pend),
    .busy       (busy),
    .served_cnt (served_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: pending set, the batch still to be issued, served count.
  logic [11:0] m_pend;
  logic [15:0] m_cnt;
  logic [3:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pend = '0;
    m_cnt  = '0;
    exp_q.delete();
  endtask

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_edge();
    logic [11:0] p;
    logic [11:0] clr;
    logic [3:0]  id;
    int          taken;
    p   = m_pend;
    clr = '0;
    if (flush) begin
      m_pend = '0;
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) begin
        taken = 0;
        for (int i = 11; i >= 0; i--) begin
          if (p[i] && taken < 2) begin
            exp_q.push_back(4'(i));
            taken++;
          end
        end
      end else if (gnt_ready) begin
        id  = exp_q.pop_front();
        clr = 12'(1) << id;
        m_cnt++;
      end
      m_pend = (p & ~clr) | req_in;
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(gnt_valid), 32'(exp_q.size() != 0));
    chk("busy", 32'(busy), 32'(exp_q.size() != 0));
    chk("pend", 32'(pend), 32'(m_pend));
    chk("served_cnt", 32'(served_cnt), 32'(m_cnt));
    if (exp_q.size() != 0) begin
      chk("gnt_id", 32'(gnt_id), 32'(exp_q[0]));
      chk("gnt_last", 32'(gnt_last), 32'(exp_q.size() == 1));
    end
  endtask

  task automatic cycle(input logic [11:0] r, input logic f, input logic rdy);
    @(negedge clk);
    req_in    = r;
    flush     = f;
    gnt_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(12'h000, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_clear();
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_id", 32'(gnt_id), 32'd0);
    chk("rst_last", 32'(gnt_last), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(served_cnt), 32'd0);
    @(negedge clk);
    req_in    = '0;
    flush     = 1'b0;
    gnt_ready = 1'b0;
    reset_n   = 1'b1;
    #1;
    chk("rel_pend", 32'(pend), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);
  endtask

  logic [15:0] saved_cnt;
  int          budget;
  logic [11:0] r;
  logic        f;
  logic        rdy;

  initial begin
    reset_n   = 1'b0;
    req_in    = '0;
    flush     = 1'b0;
    gnt_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_all();

    // Full drain of 0xAAA: three batches {11,9} {7,5} {3,1}.
    cycle(12'hAAA, 1'b0, 1'b1);
    drain(12);
    chk("drain_cnt", 32'(served_cnt), 32'd6);
    chk("drain_pend", 32'(pend), 32'd0);

    // Single request with its two-edge latency.
    cycle(12'h010, 1'b0, 1'b1);
    chk("single_lat0", 32'(gnt_valid), 32'd0);
    cycle(12'h000, 1'b0, 1'b1);
    chk("single_id", 32'(gnt_id), 32'd4);
    chk("single_last", 32'(gnt_last), 32'd1);
    drain(4);

    // Back-pressure with a late arrival on line 10.
    cycle(12'h280, 1'b0, 1'b0);
    cycle(12'h000, 1'b0, 1'b0);
    cycle(12'h000, 1'b0, 1'b0);
    cycle(12'h400, 1'b0, 1'b0);
    cycle(12'h000, 1'b0, 1'b0);
    cycle(12'h000, 1'b0, 1'b0);
    chk("stall_id", 32'(gnt_id), 32'd9);
    drain(10);

    // Set-wins collision on line 11.
    cycle(12'h800, 1'b0, 1'b0);
    cycle(12'h000, 1'b0, 1'b0);
    chk("coll_pre_id", 32'(gnt_id), 32'd11);
    cycle(12'h800, 1'b0, 1'b1);
    chk("coll_pend11", 32'(pend[11]), 32'd1);
    drain(6);

    // Flush while the second grant of {11,9} is presented.
    cycle(12'hA00, 1'b0, 1'b1);
    cycle(12'h000, 1'b0, 1'b0);
    cycle(12'h000, 1'b0, 1'b1);
    chk("fl_pre_id", 32'(gnt_id), 32'd9);
    saved_cnt = served_cnt;
    cycle(12'h000, 1'b1, 1'b1);
    chk("fl_valid", 32'(gnt_valid), 32'd0);
    chk("fl_cnt", 32'(served_cnt), 32'(saved_cnt));
    drain(3);

    // Reset while a grant is presented.
    cycle(12'hFFF, 1'b0, 1'b0);
    budget = 0;
    while (!gnt_valid && budget < 10) begin
      cycle(12'h000, 1'b0, 1'b0);
      budget++;
    end
    chk("pre_rst_valid", 32'(gnt_valid), 32'd1);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'h000;
      f   = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle(r, f, rdy);
    end
    drain(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
